// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one registered ALU among NREQ requesters
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   req_valid   per-requester operation request          [NREQ]
//   req_ready   per-requester grant, one-hot or zero     [NREQ]
//   req_a/req_b packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ctrl    packed op select, requester i at [2*i +: 2]
//                 00 add, 01 sub, 10 and, 11 or
//   rsp_valid   response register holds a result
//   rsp_ready   consumer accepts the response
//   rsp_id      requester index owning the response
//   rsp_result  ALU result
//   rsp_flags   {N,Z,C,V}
//   ops_done    wrapping count of response handshakes

module alu_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*WIDTH-1:0]   req_a,
   input  logic [NREQ*WIDTH-1:0]   req_b,
   input  logic [NREQ*2-1:0]       req_ctrl,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [WIDTH-1:0]        rsp_result,
   output logic [3:0]              rsp_flags,
   output logic [15:0]             ops_done
);

   localparam int IDW = $clog2(NREQ);
   localparam logic [IDW:0]   L_NREQ = (IDW+1)'(NREQ);
   localparam logic [IDW-1:0] L_LAST = IDW'(NREQ-1);

   logic              r_rsp_valid;
   logic [IDW-1:0]    r_rsp_id;
   logic [WIDTH-1:0]  r_rsp_result;
   logic [3:0]        r_rsp_flags;
   logic [15:0]       r_ops_done;
   logic [IDW-1:0]    r_ptr;

   logic              w_slot_free;
   logic              w_rsp_hs;
   logic              w_accept;
   logic [2*NREQ-1:0] w_dbl;
   logic              w_found;
   logic [IDW-1:0]    w_off;
   logic [IDW:0]      w_gnt_sum;
   logic [IDW-1:0]    w_gnt;
   logic [IDW-1:0]    w_ptr_next;
   logic [WIDTH-1:0]  w_a;
   logic [WIDTH-1:0]  w_b;
   logic [WIDTH-1:0]  w_b_eff;
   logic [1:0]        w_ctrl;
   logic              w_arith;
   logic              w_sub;
   logic [WIDTH:0]    w_sum;
   logic [WIDTH-1:0]  w_result;
   logic [3:0]        w_flags;

   assign w_slot_free = !r_rsp_valid || rsp_ready;
   assign w_rsp_hs    = r_rsp_valid && rsp_ready;

   // Doubling the valid vector and shifting by ptr puts the search order
   // ptr, ptr+1, ... at bit 0, 1, ...  Bits at or above NREQ only repeat
   // earlier positions (or are zero), so scanning all of them and keeping the
   // lowest set bit still yields the first valid requester after ptr.
   assign w_dbl = {req_valid, req_valid} >> r_ptr;

   always_comb begin
      w_found = 1'b0;
      w_off   = '0;
      for (int k = 2*NREQ-1; k >= 0; k--) begin
         if (w_dbl[k]) begin
            w_found = 1'b1;
            w_off   = IDW'(k);
         end
      end
   end

   assign w_gnt_sum = {1'b0, r_ptr} + {1'b0, w_off};

   always_comb begin
      if (w_gnt_sum >= L_NREQ) w_gnt = IDW'(w_gnt_sum - L_NREQ);
      else                     w_gnt = IDW'(w_gnt_sum);
   end

   assign w_ptr_next = (w_gnt == L_LAST) ? '0 : w_gnt + 1'b1;
   assign w_accept   = reset && w_slot_free && w_found;
   assign req_ready  = w_accept ? ({{(NREQ-1){1'b0}}, 1'b1} << w_gnt) : '0;

   // Operand mux and ALU for the granted requester.
   assign w_a     = req_a[w_gnt*WIDTH +: WIDTH];
   assign w_b     = req_b[w_gnt*WIDTH +: WIDTH];
   assign w_ctrl  = req_ctrl[2*w_gnt +: 2];
   assign w_arith = !w_ctrl[1];
   assign w_sub   = (w_ctrl == 2'b01);
   assign w_b_eff = w_sub ? ~w_b : w_b;
   assign w_sum   = {1'b0, w_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};

   always_comb begin
      case (w_ctrl)
         2'b10:   w_result = w_a & w_b;
         2'b11:   w_result = w_a | w_b;
         default: w_result = w_sum[WIDTH-1:0];
      endcase
   end

   assign w_flags[3] = w_result[WIDTH-1];
   assign w_flags[2] = (w_result == '0);
   assign w_flags[1] = w_arith && w_sum[WIDTH];
   assign w_flags[0] = w_arith && (w_a[WIDTH-1] == w_b_eff[WIDTH-1])
                               && (w_sum[WIDTH-1] != w_a[WIDTH-1]);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= '0;
         r_rsp_result <= '0;
         r_rsp_flags  <= '0;
         r_ops_done   <= '0;
         r_ptr        <= '0;
      end else begin
         if (w_accept) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= w_gnt;
            r_rsp_result <= w_result;
            r_rsp_flags  <= w_flags;
            r_ptr        <= w_ptr_next;
         end else if (w_rsp_hs) begin
            r_rsp_valid  <= 1'b0;
         end
         if (w_rsp_hs) r_ops_done <= r_ops_done + 16'd1;
      end
   end

   assign rsp_valid  = r_rsp_valid;
   assign rsp_id     = r_rsp_id;
   assign rsp_result = r_rsp_result;
   assign rsp_flags  = r_rsp_flags;
   assign ops_done   = r_ops_done;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter

module tb_alu_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [127:0] req_a;
   logic [127:0] req_b;
   logic [7:0]  req_ctrl;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic [31:0] rsp_result;
   logic [3:0]  rsp_flags;
   logic [15:0] ops_done;

   int n_tests;
   int n_fail;

   alu_arbiter #(.NREQ(4), .WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ctrl   (req_ctrl),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_flags  (rsp_flags),
      .ops_done   (ops_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] c);
      req_a[i*32 +: 32] = a;
      req_b[i*32 +: 32] = b;
      req_ctrl[2*i +: 2] = c;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
      n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rsp_valid); end
      n_tests++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d expected 0", rsp_id); end
      n_tests++; if (rsp_result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", rsp_result); end
      n_tests++; if (rsp_flags !== 4'h0) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", rsp_flags); end
      n_tests++; if (ops_done !== 16'h0) begin n_fail++; $display("FAIL reset_ops_done: got %0d expected 0", ops_done); end
      req_valid = 4'b0000;
      reset = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      rsp_ready = 1'b1;
      set_req(2, 32'd5, 32'd3, 2'b01);
      req_valid = 4'b0100;
      #1;
      n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
      @(posedge clk); #1;
      req_valid = 4'b0000;
      n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", rsp_valid); end
      n_tests++; if (rsp_id !== 2'd2) begin n_fail++; $display("FAIL single_id: got %0d expected 2", rsp_id); end
      n_tests++; if (rsp_result !== 32'd2) begin n_fail++; $display("FAIL single_result: got %h expected 2", rsp_result); end
      n_tests++; if (rsp_flags !== 4'b0010) begin n_fail++; $display("FAIL single_flags: got %b expected 0010", rsp_flags); end
      @(posedge clk); #1;
      n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b expected 0", rsp_valid); end
      n_tests++; if (ops_done !== 16'd1) begin n_fail++; $display("FAIL single_ops_done: got %0d expected 1", ops_done); end
   endtask

   task automatic test_fairness();
      logic [31:0] exp_res;
      logic [3:0]  exp_rdy;
      do_reset();
      for (int i = 0; i < 4; i++) set_req(i, 32'(10*(i+1)), 32'(i), 2'b00);
      rsp_ready = 1'b1;
      req_valid = 4'b1111;
      #1;
      for (int c = 0; c < 8; c++) begin
         exp_rdy = 4'b0001 << (c % 4);
         exp_res = 32'(11*(c % 4) + 10);
         n_tests++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL fair_ready[%0d]: got %b expected %b", c, req_ready, exp_rdy); end
         @(posedge clk); #1;
         if (c == 7) req_valid = 4'b0000;
         n_tests++; if (rsp_id !== 2'(c % 4)) begin n_fail++; $display("FAIL fair_id[%0d]: got %0d expected %0d", c, rsp_id, c % 4); end
         n_tests++; if (rsp_result !== exp_res) begin n_fail++; $display("FAIL fair_result[%0d]: got %0d expected %0d", c, rsp_result, exp_res); end
         #1;
      end
      @(posedge clk); #1;
      n_tests++; if (ops_done !== 16'd8) begin n_fail++; $display("FAIL fair_ops_done: got %0d expected 8", ops_done); end
      n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL fair_drain: got %b expected 0", rsp_valid); end
   endtask

   task automatic test_backpressure();
      rsp_ready = 1'b0;
      set_req(0, 32'd100, 32'd1, 2'b01);
      req_valid = 4'b0001;
      #1;
      n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_first_ready: got %b expected 0001", req_ready); end
      @(posedge clk); #1;
      set_req(1, 32'd7, 32'd9, 2'b00);
      req_valid = 4'b0010;
      #1;
      for (int c = 0; c < 3; c++) begin
         n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b expected 0000", c, req_ready); end
         n_tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 32'd99 || rsp_flags !== 4'b0010)
            begin n_fail++; $display("FAIL bp_hold[%0d]: got v%b id%0d r%0d f%b expected v1 id0 r99 f0010", c, rsp_valid, rsp_id, rsp_result, rsp_flags); end
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      #1;
      n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 0010", req_ready); end
      @(posedge clk); #1;
      req_valid = 4'b0000;
      n_tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== 32'd16)
         begin n_fail++; $display("FAIL bp_next: got v%b id%0d r%0d expected v1 id1 r16", rsp_valid, rsp_id, rsp_result); end
      n_tests++; if (ops_done !== 16'd9) begin n_fail++; $display("FAIL bp_ops_mid: got %0d expected 9", ops_done); end
      @(posedge clk); #1;
      n_tests++; if (ops_done !== 16'd10) begin n_fail++; $display("FAIL bp_ops_end: got %0d expected 10", ops_done); end
   endtask

   task automatic test_flags();
      logic [31:0] va [5];
      logic [31:0] vb [5];
      logic [1:0]  vc [5];
      logic [31:0] vr [5];
      logic [3:0]  vf [5];
      va[0] = 32'h7FFFFFFF; vb[0] = 32'h1;        vc[0] = 2'b00; vr[0] = 32'h80000000; vf[0] = 4'b1001;
      va[1] = 32'hFFFFFFFF; vb[1] = 32'hFFFFFFFF; vc[1] = 2'b01; vr[1] = 32'h0;        vf[1] = 4'b0110;
      va[2] = 32'h000000F0; vb[2] = 32'h0000000F; vc[2] = 2'b10; vr[2] = 32'h0;        vf[2] = 4'b0100;
      va[3] = 32'h0;        vb[3] = 32'h1;        vc[3] = 2'b01; vr[3] = 32'hFFFFFFFF; vf[3] = 4'b1000;
      va[4] = 32'h000000F0; vb[4] = 32'h0000000F; vc[4] = 2'b11; vr[4] = 32'hFF;       vf[4] = 4'b0000;
      rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         set_req(3, va[i], vb[i], vc[i]);
         req_valid = 4'b1000;
         @(posedge clk); #1;
         n_tests++; if (rsp_result !== vr[i]) begin n_fail++; $display("FAIL flags_result[%0d]: got %h expected %h", i, rsp_result, vr[i]); end
         n_tests++; if (rsp_flags !== vf[i]) begin n_fail++; $display("FAIL flags_nzcv[%0d]: got %b expected %b", i, rsp_flags, vf[i]); end
      end
      req_valid = 4'b0000;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      rsp_ready = 1'b0;
      set_req(0, 32'd1, 32'd1, 2'b00);
      req_valid = 4'b0001;
      @(posedge clk); #1;
      n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pending: got %b expected 1", rsp_valid); end
      reset = 1'b0;
      #1;
      n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b expected 0", rsp_valid); end
      n_tests++; if (ops_done !== 16'd0) begin n_fail++; $display("FAIL mid_ops_done: got %0d expected 0", ops_done); end
      n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_ready_in_reset: got %b expected 0000", req_ready); end
      set_req(3, 32'd4, 32'd4, 2'b00);
      req_valid = 4'b1001;
      rsp_ready = 1'b1;
      #1;
      reset = 1'b1;
      #1;
      n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_first_grant: got %b expected 0001", req_ready); end
      @(posedge clk); #1;
      req_valid = 4'b1000;
      n_tests++; if (rsp_id !== 2'd0 || rsp_result !== 32'd2) begin n_fail++; $display("FAIL mid_rsp0: got id%0d r%0d expected id0 r2", rsp_id, rsp_result); end
      #1;
      n_tests++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL mid_second_grant: got %b expected 1000", req_ready); end
      @(posedge clk); #1;
      req_valid = 4'b0000;
      n_tests++; if (rsp_id !== 2'd3 || rsp_result !== 32'd8) begin n_fail++; $display("FAIL mid_rsp3: got id%0d r%0d expected id3 r8", rsp_id, rsp_result); end
      @(posedge clk); #1;
   endtask

   task automatic test_wrap();
      do_reset();
      set_req(0, 32'd1, 32'd2, 2'b00);
      rsp_ready = 1'b1;
      req_valid = 4'b0001;
      repeat (65536) @(posedge clk);
      #1;
      n_tests++; if (ops_done !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h expected ffff", ops_done); end
      @(posedge clk); #1;
      n_tests++; if (ops_done !== 16'h0000) begin n_fail++; $display("FAIL wrap_rollover: got %h expected 0000", ops_done); end
      req_valid = 4'b0000;
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      reset     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_ctrl  = '0;
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_flags();
      test_reset_mid();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the ALU; legal range 2..8.
REQ-002 Parameter WIDTH, default 32: operand and result width.
REQ-003 clk  input  1  single clock for the block; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  NREQ  per-requester operation request.
REQ-006 req_ready  output  NREQ  per-requester acceptance; at most one bit high per cycle.
REQ-007 req_a  input  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 req_b  input  NREQ*WIDTH  operand B; same packing as req_a.
REQ-009 req_ctrl  input  NREQ*2  ALU control; requester i occupies bits [2*i +: 2].
REQ-010 rsp_valid  output  1  response register holds a result.
REQ-011 rsp_ready  input  1  consumer accepts the response.
REQ-012 rsp_id  output  clog2(NREQ)  index of the requester that owns the response.
REQ-013 rsp_result  output  WIDTH  operation result.
REQ-014 rsp_flags  output  4  {N,Z,C,V} for the result.
REQ-015 ops_done  output  16  count of completed response handshakes.

Function
REQ-016 Accept for requester i = req_valid[i] & req_ready[i]; response handshake = rsp_valid & rsp_ready.
REQ-017 Slot free = !rsp_valid | rsp_ready (response register empty, or draining this cycle).
REQ-018 If slot free and any req_valid, exactly one req_ready bit asserts, combinationally, for the first valid requester searching ptr, ptr+1, ... mod NREQ; otherwise req_ready is all zero.
REQ-019 req_ready does not depend on req_ctrl, req_a or req_b.
REQ-020 Round-robin pointer ptr: on accept of requester i, ptr <= (i+1) mod NREQ; no accept, ptr unchanged.
REQ-021 Ops by ctrl: 00 = a+b; 01 = a-b, computed as a + ~b + 1; 10 = a&b; 11 = a|b.
REQ-022 Add/sub use a WIDTH+1-bit sum; C = bit WIDTH of that sum (for sub, C=1 means no borrow).
REQ-023 V for add/sub = (a[msb]==b'[msb]) & (sum[msb]!=a[msb]), where b' is the effective operand (~b for sub); C=V=0 for AND/OR.
REQ-024 N = result[msb]; Z = (result==0); both valid for all ops.
REQ-025 Latency: result of an op accepted in cycle t is on rsp_* with rsp_valid=1 in cycle t+1.
REQ-026 Accept in the same cycle as a response handshake loads the new result; rsp_valid stays 1, giving one op per cycle sustained throughput.
REQ-027 Response handshake with no accept clears rsp_valid next cycle.
REQ-028 While rsp_valid=1 and rsp_ready=0: rsp_id, rsp_result and rsp_flags are held stable, and req_ready is all zero.
REQ-029 ops_done increments by 1 on each response handshake and wraps 0xFFFF -> 0x0000.
REQ-030 Requester protocol: once req_valid[i] is asserted, it and its operands stay stable until accepted. The block does not check this.
REQ-031 rsp_* outputs and ops_done come from registers only; no combinational path from req_* to rsp_*.

Reset
REQ-032 On reset low, asynchronously: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, ops_done=0, ptr=0.
REQ-033 While reset is low, req_ready is all zero.
REQ-034 Reset asserted with a pending response discards that response; it is not counted in ops_done.
REQ-035 First arbitration after reset release starts search at requester 0.

Verification
REQ-036 Single request: after reset, req 2 valid with a=5, b=3, ctrl=01 -> req_ready=0100 same cycle; next cycle rsp_valid=1, rsp_id=2, result=2, flags N0 Z0 C1 V0.
REQ-037 Fairness: all 4 requesters continuously valid, rsp_ready=1 -> grants in order 0,1,2,3,0,... one per cycle; ops_done=8 after 8 handshakes.
REQ-038 Backpressure: rsp_ready=0 for 3 cycles with response pending and req 1 valid -> rsp_* held, req_ready=0000; rsp_ready=1 -> req 1 accepted that same cycle, its result appears next cycle.
REQ-039 Flags: a=0x7FFFFFFF, b=1, ctrl=00 -> result 0x80000000, N1 Z0 C0 V1; a=b=0xFFFFFFFF, ctrl=01 -> result 0, N0 Z1 C1 V0; ctrl=10 with a=0xF0, b=0x0F -> result 0, Z1 C0 V0.
REQ-040 Reset mid-operation: reset low while rsp_valid=1 -> rsp_valid=0 immediately, ops_done=0; after release, req 3 and req 0 both valid -> req 0 granted first.
REQ-041 Counter wrap: with ops_done preloaded to 0xFFFF by 65535 handshakes, one more handshake -> ops_done=0x0000.
